// File: rtl/fac_host_ctrl.sv
// fac_host_ctrl: bus master that runs one factorial job on the memory-mapped
// factorial slave and returns the 128-bit result.
//
// Register sequence per command:
//   clear (opclear=1 then 0), intrEn, operand, opstart=1,
//   wait (interrupt or opdone polling),
//   read result_h and result_l, opstart=0.
// If the wait times out, the block writes opstart=0 and then opclear=1,
// and reports an error. The result outputs are left unchanged.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_operand, cmd_use_intr     operand n, completion mode (1=interrupt)
//   rsp_done, rsp_err             one-cycle completion pulse, abort qualifier
//   rsp_result_h/l                upper/lower 64 bits of n!
//   m_req/m_grant/m_wr/m_addr     bus transfer request/accept/direction/address
//   m_dout, m_din                 write data, read data (valid cycle after grant)
//   interrupt                     slave interrupt level
module fac_host_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          POLL_GAP  = 4,
    parameter int          TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_operand,
    input  logic        cmd_use_intr,
    output logic        rsp_done,
    output logic        rsp_err,
    output logic [63:0] rsp_result_h,
    output logic [63:0] rsp_result_l,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt
);

    localparam logic [2:0] OFF_START = 3'd0;
    localparam logic [2:0] OFF_CLEAR = 3'd1;
    localparam logic [2:0] OFF_DONE  = 3'd2;
    localparam logic [2:0] OFF_IEN   = 3'd3;
    localparam logic [2:0] OFF_OPND  = 3'd4;
    localparam logic [2:0] OFF_RESH  = 3'd5;
    localparam logic [2:0] OFF_RESL  = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR1, S_CLR0, S_INTR, S_OPND, S_START, S_WAIT, S_POLL,
        S_PCHK, S_RDH, S_RDL, S_STOP, S_ABT0, S_ABT1, S_RSP
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      bus_after;
    logic [63:0] operand;
    logic        intr_mode;
    logic [31:0] tmo_cnt;
    logic [31:0] gap_cnt;
    logic        cap_h;
    logic        cap_l;
    logic        count_en;
    logic        bus_state;
    logic        bus_wr;
    logic [2:0]  bus_off;
    logic [63:0] bus_data;
    logic        req_next;
    logic        wr_next;
    logic [15:0] addr_next;
    logic [63:0] dout_next;

    // Timeout counts only cycles spent waiting; a stalled poll read does not count.
    assign count_en = (state == S_WAIT) || (state == S_PCHK) ||
                      ((state == S_POLL) && !(m_req && !m_grant));

    // Next-state and next bus-output logic.
    always_comb begin
        state_next = state;
        bus_after  = state;
        bus_state  = 1'b0;
        bus_wr     = 1'b0;
        bus_off    = 3'd0;
        bus_data   = 64'd0;
        req_next   = 1'b0;
        wr_next    = m_wr;
        addr_next  = m_addr;
        dout_next  = m_dout;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_next = S_CLR1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_CLR1:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_CLEAR; bus_data = 64'd1; bus_after = S_CLR0; end
            S_CLR0:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_CLEAR; bus_data = 64'd0; bus_after = S_INTR; end
            S_INTR:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_IEN;   bus_data = {63'd0, intr_mode}; bus_after = S_OPND; end
            S_OPND:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_OPND;  bus_data = operand; bus_after = S_START; end
            S_START: begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_START; bus_data = 64'd1; bus_after = S_WAIT; end
            S_WAIT: begin
                if (tmo_cnt >= 32'(TIMEOUT)) begin
                    state_next = S_ABT0;
                end else if (intr_mode) begin
                    if (interrupt) begin
                        state_next = S_RDH;
                    end else begin
                        state_next = S_WAIT;
                    end
                end else if ((gap_cnt + 32'd1) >= 32'(POLL_GAP)) begin
                    state_next = S_POLL;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_POLL:  begin bus_state = 1'b1; bus_off = OFF_DONE; bus_after = S_PCHK; end
            // Poll data is on m_din in the cycle right after the read grant.
            S_PCHK: begin
                if (m_din[0]) begin
                    state_next = S_RDH;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_RDH:   begin bus_state = 1'b1; bus_off = OFF_RESH; bus_after = S_RDL; end
            S_RDL:   begin bus_state = 1'b1; bus_off = OFF_RESL; bus_after = S_STOP; end
            S_STOP:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_START; bus_data = 64'd0; bus_after = S_RSP; end
            S_ABT0:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_START; bus_data = 64'd0; bus_after = S_ABT1; end
            S_ABT1:  begin bus_state = 1'b1; bus_wr = 1'b1; bus_off = OFF_CLEAR; bus_data = 64'd1; bus_after = S_RSP; end
            S_RSP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // A bus state issues its request when m_req is low. It holds the
        // request until it is granted, and then it drops m_req for one cycle.
        if (bus_state) begin
            if (m_req) begin
                if (m_grant) begin
                    req_next   = 1'b0;
                    state_next = bus_after;
                end else begin
                    req_next   = 1'b1;
                end
            end else begin
                req_next  = 1'b1;
                wr_next   = bus_wr;
                addr_next = BASE_ADDR + {10'd0, bus_off, 3'b000};
                dout_next = bus_data;
            end
        end else begin
            req_next = 1'b0;
        end
    end

    // State, bus outputs, command latch, counters and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            m_req        <= 1'b0;
            m_wr         <= 1'b0;
            m_addr       <= 16'd0;
            m_dout       <= 64'd0;
            operand      <= 64'd0;
            intr_mode    <= 1'b0;
            tmo_cnt      <= 32'd0;
            gap_cnt      <= 32'd0;
            cap_h        <= 1'b0;
            cap_l        <= 1'b0;
            cmd_ready    <= 1'b0;
            rsp_done     <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_result_h <= 64'd0;
            rsp_result_l <= 64'd1;
        end else begin
            state  <= state_next;
            m_req  <= req_next;
            m_wr   <= wr_next;
            m_addr <= addr_next;
            m_dout <= dout_next;
            if ((state == S_IDLE) && cmd_valid && cmd_ready) begin
                operand   <= cmd_operand;
                intr_mode <= cmd_use_intr;
                tmo_cnt   <= 32'd0;
            end else if (count_en) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            gap_cnt <= ((state == S_WAIT) && (state_next == S_WAIT)) ? gap_cnt + 32'd1 : 32'd0;
            cap_h   <= (state == S_RDH) && m_req && m_grant;
            cap_l   <= (state == S_RDL) && m_req && m_grant;
            if (cap_h) begin
                rsp_result_h <= m_din;
            end
            if (cap_l) begin
                rsp_result_l <= m_din;
            end
            cmd_ready <= (state_next == S_IDLE);
            rsp_done  <= (state_next == S_RSP);
            rsp_err   <= (state_next == S_RSP) && (state == S_ABT1);
        end
    end

endmodule

// File: tb/tb_fac_host_ctrl.sv
module tb_fac_host_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_operand = 64'd0;
    logic        cmd_use_intr = 1'b0;
    logic        rsp_done, rsp_err;
    logic [63:0] rsp_result_h, rsp_result_l;
    logic        m_req, m_grant, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] m_din = 64'd0;
    logic        interrupt;

    int checks = 0;
    int errors = 0;

    fac_host_ctrl #(.BASE_ADDR(16'h0000), .POLL_GAP(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_operand(cmd_operand), .cmd_use_intr(cmd_use_intr),
        .rsp_done(rsp_done), .rsp_err(rsp_err),
        .rsp_result_h(rsp_result_h), .rsp_result_l(rsp_result_l),
        .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .m_din(m_din), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
    } xfer_t;

    xfer_t bus_log[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (longint unsigned i = 2; i <= n; i++) r = r * 128'(i);
        return r;
    endfunction

    function automatic xfer_t mk(input logic wr, input logic [15:0] addr, input logic [63:0] data);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.data = data;
        return x;
    endfunction

    // ---------------- slave model and grant generator ----------------
    logic         sl_start = 1'b0, sl_done = 1'b0, sl_ien = 1'b0;
    logic [63:0]  sl_opnd = 64'd0;
    logic [127:0] sl_res = 128'd1;
    int           sl_cnt = 0;
    int           sl_lat = 5;
    bit           never_done = 1'b0;
    logic         gnt_ok = 1'b1;
    bit           rand_grant = 1'b0;
    bit           stall_mode = 1'b0;
    int           stall_cnt = 0;

    assign m_grant   = m_req & gnt_ok;
    assign interrupt = sl_done & sl_ien & sl_start;

    function automatic logic [63:0] sl_read(input logic [15:0] a);
        case (a[5:3])
            3'd0:    return {63'd0, sl_start};
            3'd2:    return {63'd0, sl_done};
            3'd3:    return {63'd0, sl_ien};
            3'd4:    return sl_opnd;
            3'd5:    return sl_res[127:64];
            3'd6:    return sl_res[63:0];
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (sl_start && !sl_done && !never_done) begin
            if (sl_cnt <= 1) sl_done <= 1'b1;
            else sl_cnt <= sl_cnt - 1;
        end
        if (m_req && m_grant) begin
            if (m_wr) begin
                bus_log.push_back(mk(1'b1, m_addr, m_dout));
                case (m_addr[5:3])
                    3'd0: begin
                        if (m_dout[0]) begin
                            sl_start <= 1'b1; sl_done <= 1'b0; sl_cnt <= sl_lat;
                            sl_res <= fact(sl_opnd);
                        end else begin
                            sl_start <= 1'b0;
                        end
                    end
                    3'd1: if (m_dout[0]) sl_done <= 1'b0;
                    3'd3: sl_ien <= m_dout[0];
                    3'd4: sl_opnd <= m_dout;
                    default: ;
                endcase
            end else begin
                bus_log.push_back(mk(1'b0, m_addr, sl_read(m_addr)));
                m_din <= sl_read(m_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (stall_mode && m_req && m_wr && m_addr == 16'h0020 && stall_cnt < 10) begin
            gnt_ok <= 1'b0;
            stall_cnt <= stall_cnt + 1;
        end else if (rand_grant) begin
            gnt_ok <= ($urandom_range(0, 2) != 0);
        end else begin
            gnt_ok <= 1'b1;
        end
    end

    // Bus protocol watch: ungranted requests stay stable, m_req drops after a grant.
    logic        held_v = 1'b0, gnt_last = 1'b0, held_wr = 1'b0;
    logic [15:0] held_addr = 16'd0;
    logic [63:0] held_dout = 64'd0;
    always @(posedge clk) begin
        held_v    <= m_req && !m_grant && reset_n;
        gnt_last  <= m_req && m_grant && reset_n;
        held_wr   <= m_wr;
        held_addr <= m_addr;
        held_dout <= m_dout;
    end
    always @(negedge clk) begin
        if (reset_n && held_v) begin
            chk("hold_req", m_req, 1'b1);
            chk("hold_bus", {m_wr, m_addr, m_dout}, {held_wr, held_addr, held_dout});
        end
        if (reset_n && gnt_last) chk("req_gap", m_req, 1'b0);
    end

    // ---------------- command driver and checks ----------------
    logic        got, r_err;
    logic [63:0] r_h, r_l;

    task automatic run_cmd(input logic [63:0] n, input logic intr);
        bus_log.delete();
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (cmd_ready) break;
            @(posedge clk); #1;
        end
        chk("ready_before", cmd_ready, 1'b1);
        cmd_operand = n; cmd_use_intr = intr; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("ready_busy", cmd_ready, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rsp_done) begin got = 1'b1; break; end
        end
        chk("done_seen", got, 1'b1);
        r_err = rsp_err; r_h = rsp_result_h; r_l = rsp_result_l;
        @(posedge clk); #1;
        chk("done_pulse", rsp_done, 1'b0);
        chk("ready_after", cmd_ready, 1'b1);
    endtask

    task automatic chk_x(input string tag, input int k, input xfer_t e);
        xfer_t o;
        o = '1;
        if (k < bus_log.size()) o = bus_log[k];
        chk(tag, 128'(o), 128'(e));
    endtask

    // Expected register traffic for one command, derived from the sequence rules.
    task automatic check_log(input logic [63:0] n, input logic intr, input bit aborted);
        int k, polls;
        logic [127:0] res;
        res = fact(n);
        chk_x("w_clr1", 0, mk(1'b1, 16'h0008, 64'd1));
        chk_x("w_clr0", 1, mk(1'b1, 16'h0008, 64'd0));
        chk_x("w_ien",  2, mk(1'b1, 16'h0018, {63'd0, intr}));
        chk_x("w_opnd", 3, mk(1'b1, 16'h0020, n));
        chk_x("w_start", 4, mk(1'b1, 16'h0000, 64'd1));
        k = 5; polls = 0;
        while (k < bus_log.size() && !bus_log[k].wr && bus_log[k].addr == 16'h0010) begin
            k++; polls++;
        end
        if (intr) chk("intr_no_poll", polls, 0);
        else if (!aborted) begin
            chk("poll_seen", polls > 0, 1'b1);
            if (polls > 0) chk("poll_last_done", bus_log[k-1].data[0], 1'b1);
        end
        if (aborted) begin
            chk_x("abt_stop", k, mk(1'b1, 16'h0000, 64'd0));
            chk_x("abt_clr", k + 1, mk(1'b1, 16'h0008, 64'd1));
            k += 2;
        end else begin
            chk_x("r_resh", k, mk(1'b0, 16'h0028, res[127:64]));
            chk_x("r_resl", k + 1, mk(1'b0, 16'h0030, res[63:0]));
            chk_x("w_stop", k + 2, mk(1'b1, 16'h0000, 64'd0));
            k += 3;
        end
        chk("log_len", bus_log.size(), k);
    endtask

    initial begin
        logic [63:0] n;
        logic        intr;
        logic [127:0] f;

        // reset state
        @(posedge clk); #1;
        chk("rst_req", m_req, 1'b0);
        chk("rst_bus", {m_wr, m_addr, m_dout}, 81'd0);
        chk("rst_rsp", {rsp_done, rsp_err}, 2'b00);
        chk("rst_res", {rsp_result_h, rsp_result_l}, {64'd0, 64'd1});
        chk("rst_ready", cmd_ready, 1'b0);
        reset_n = 1'b1;

        // poll mode, n=5
        run_cmd(64'd5, 1'b0);
        chk("p5_res", {r_err, r_h, r_l}, {1'b0, 64'd0, 64'd120});
        check_log(64'd5, 1'b0, 1'b0);

        // interrupt mode, n=21
        sl_lat = 12;
        run_cmd(64'd21, 1'b1);
        chk("i21_res", {r_err, r_h, r_l}, {1'b0, 64'h2, 64'hC5077D36B8C40000});
        check_log(64'd21, 1'b1, 1'b0);

        // n=0
        sl_lat = 3;
        run_cmd(64'd0, 1'b0);
        chk("p0_res", {r_err, r_h, r_l}, {1'b0, 64'd0, 64'd1});
        check_log(64'd0, 1'b0, 1'b0);

        // 10-cycle grant stall on the operand write
        stall_cnt = 0; stall_mode = 1'b1;
        run_cmd(64'd9, 1'b0);
        stall_mode = 1'b0;
        chk("stall_cycles", stall_cnt, 10);
        chk("stall_res", {r_err, r_h, r_l}, {1'b0, 64'd0, 64'd362880});
        check_log(64'd9, 1'b0, 1'b0);

        // timeout: slave never finishes, results keep n=9 values
        never_done = 1'b1;
        run_cmd(64'd7, 1'b0);
        chk("tmo_res", {r_err, r_h, r_l}, {1'b1, 64'd0, 64'd362880});
        check_log(64'd7, 1'b0, 1'b1);

        // reset pulse while waiting
        cmd_operand = 64'd11; cmd_use_intr = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", m_req, 1'b0);
        chk("mid_rst_bus", {m_wr, m_addr, m_dout}, 81'd0);
        chk("mid_rst_rsp", {rsp_done, rsp_err, cmd_ready}, 3'b000);
        chk("mid_rst_res", {rsp_result_h, rsp_result_l}, {64'd0, 64'd1});
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        never_done = 1'b0;
        run_cmd(64'd3, 1'b0);
        chk("after_rst_res", {r_err, r_h, r_l}, {1'b0, 64'd0, 64'd6});
        check_log(64'd3, 1'b0, 1'b0);

        // randomized commands against the factorial model
        for (int it = 0; it < 8; it++) begin
            n = 64'($urandom_range(0, 30));
            intr = 1'($urandom_range(0, 1));
            rand_grant = 1'($urandom_range(0, 1));
            sl_lat = $urandom_range(1, 30);
            run_cmd(n, intr);
            f = fact(n);
            chk("rand_res", {r_err, r_h, r_l}, {1'b0, f});
            check_log(n, intr, 1'b0);
        end
        rand_grant = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
